// File: rtl/conv9_pkg.sv
// Shared constants, FSM state type and accumulator sizing for the 9x9 row-accumulating convolver.
// Holds no logic, so it adds no latency and applies no backpressure.
package conv9_pkg;
   localparam int KERNEL_TAPS    = 9;
   localparam int KERNEL_ROWS    = 9;
   localparam int ACC_GUARD_BITS = 8;
   localparam int ACC_WIDTH      = 18 + 8 + 1 + ACC_GUARD_BITS;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } acc_state_e;

   function automatic int acc_width(input int pixel_w, input int weight_w);
      return weight_w + pixel_w + 1 + ACC_GUARD_BITS;
   endfunction
endpackage

// File: rtl/conv9_row_mac.sv
// 9-tap row MAC: products registered in S1, full-width adder tree in S2; 2-cycle latency.
// No backpressure: it accepts one row per cycle, and the row number and valid bit travel with the data.
module conv9_row_mac
   import conv9_pkg::*;
#(
   parameter int PIXEL_WIDTH  = 8,
   parameter int WEIGHT_WIDTH = 18,
   parameter int SUM_WIDTH    = PIXEL_WIDTH + WEIGHT_WIDTH + 1 + 4
) (
   input  logic                                     clk_in,
   input  logic                                     rst_in,
   input  logic                                     row_vld_in,
   input  logic [3:0]                               row_num_in,
   input  logic [KERNEL_TAPS-1:0][WEIGHT_WIDTH-1:0] weight_row_in,
   input  logic [KERNEL_TAPS-1:0][PIXEL_WIDTH-1:0]  pixel_row_in,
   output logic                                     sum_vld_out,
   output logic [3:0]                               sum_row_out,
   output logic signed [SUM_WIDTH-1:0]              sum_out
);
   localparam int PROD_W = PIXEL_WIDTH + 1 + WEIGHT_WIDTH;

   logic signed [PROD_W-1:0]    prod_d [KERNEL_TAPS];
   logic signed [PROD_W-1:0]    prod_q [KERNEL_TAPS];
   logic                        s1_vld_d, s1_vld_q;
   logic [3:0]                  s1_row_d, s1_row_q;
   logic signed [SUM_WIDTH-1:0] sum_d, sum_q;
   logic                        s2_vld_d, s2_vld_q;
   logic [3:0]                  s2_row_d, s2_row_q;

   always_comb begin
      s1_vld_d = row_vld_in;
      s1_row_d = row_num_in;
      for (int t = 0; t < KERNEL_TAPS; t++) begin
         // The zero-extended pixel is treated as signed, so it can never read as negative.
         prod_d[t] = PROD_W'($signed({1'b0, pixel_row_in[t]})) * PROD_W'($signed(weight_row_in[t]));
      end
      s2_vld_d = s1_vld_q;
      s2_row_d = s1_row_q;
      sum_d    = '0;
      for (int t = 0; t < KERNEL_TAPS; t++) begin
         sum_d = sum_d + SUM_WIDTH'(prod_q[t]);
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_vld_q <= 1'b0;
         s1_row_q <= '0;
         for (int t = 0; t < KERNEL_TAPS; t++) prod_q[t] <= '0;
         s2_vld_q <= 1'b0;
         s2_row_q <= '0;
         sum_q    <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_row_q <= s1_row_d;
         for (int t = 0; t < KERNEL_TAPS; t++) prod_q[t] <= prod_d[t];
         s2_vld_q <= s2_vld_d;
         s2_row_q <= s2_row_d;
         sum_q    <= sum_d;
      end
   end

   assign sum_vld_out = s2_vld_q;
   assign sum_row_out = s2_row_q;
   assign sum_out     = sum_q;
endmodule

// File: rtl/conv9_row_accumulator.sv
// Accumulates nine kernel rows into one shifted, saturated result; row 8 in gives result_valid 4 cycles later.
// The input side never stalls; a result that finishes while the output register is still unread is dropped and flagged.
module conv9_row_accumulator
   import conv9_pkg::*;
#(
   parameter int PIXEL_WIDTH  = 8,
   parameter int WEIGHT_WIDTH = 18,
   parameter int FRAC_BITS    = 10,
   parameter int OUT_WIDTH    = 18
) (
   input  logic                                     clk_in,
   input  logic                                     rst_in,
   input  logic [KERNEL_TAPS-1:0][WEIGHT_WIDTH-1:0] weight_row_in,
   input  logic [3:0]                               row_num_in,
   input  logic [KERNEL_TAPS-1:0][PIXEL_WIDTH-1:0]  pixel_row_in,
   input  logic                                     data_valid_in,
   output logic signed [OUT_WIDTH-1:0]              result_out,
   output logic                                     result_valid,
   input  logic                                     result_ready,
   output logic                                     seq_error,
   output logic                                     overflow
);
   localparam int ACC_W    = acc_width(PIXEL_WIDTH, WEIGHT_WIDTH);
   localparam int SUM_W    = PIXEL_WIDTH + WEIGHT_WIDTH + 1 + 4;
   localparam logic [3:0] LAST_ROW = 4'(KERNEL_ROWS - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic                     s2_vld;
   logic [3:0]               s2_row;
   logic signed [SUM_W-1:0]  s2_sum;
   logic signed [ACC_W-1:0]  row_sum;

   acc_state_e               state_d, state_q;
   logic [3:0]               exp_row_d, exp_row_q;
   logic signed [ACC_W-1:0]  acc_d, acc_q;
   logic signed [ACC_W-1:0]  fin_d, fin_q;
   logic                     fin_vld_d, fin_vld_q;
   logic                     seq_error_d, seq_error_q;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [OUT_WIDTH-1:0] sat_val;
   logic signed [OUT_WIDTH-1:0] res_d, res_q;
   logic                     res_vld_d, res_vld_q;
   logic                     overflow_d, overflow_q;

   conv9_row_mac #(
      .PIXEL_WIDTH  (PIXEL_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .SUM_WIDTH    (SUM_W)
   ) u_mac (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .row_vld_in    (data_valid_in),
      .row_num_in    (row_num_in),
      .weight_row_in (weight_row_in),
      .pixel_row_in  (pixel_row_in),
      .sum_vld_out   (s2_vld),
      .sum_row_out   (s2_row),
      .sum_out       (s2_sum)
   );

   assign row_sum = ACC_W'(s2_sum);

   always_comb begin
      state_d     = state_q;
      exp_row_d   = exp_row_q;
      acc_d       = acc_q;
      fin_d       = fin_q;
      fin_vld_d   = 1'b0;
      seq_error_d = seq_error_q;
      if (s2_vld) begin
         if (state_q == IDLE) begin
            if (s2_row == 4'd0) begin
               acc_d     = row_sum;
               exp_row_d = 4'd1;
               state_d   = ACCUM;
            end else begin
               seq_error_d = 1'b1;
            end
         end else if (s2_row == exp_row_q && s2_row < LAST_ROW) begin
            acc_d     = acc_q + row_sum;
            exp_row_d = exp_row_q + 4'd1;
         end else if (s2_row == LAST_ROW && exp_row_q == LAST_ROW) begin
            fin_d     = acc_q + row_sum;
            fin_vld_d = 1'b1;
            acc_d     = '0;
            exp_row_d = 4'd0;
            state_d   = IDLE;
         end else if (s2_row == 4'd0) begin
            // A fresh row 0 mid-frame abandons the old frame but starts a new one immediately.
            seq_error_d = 1'b1;
            acc_d       = row_sum;
            exp_row_d   = 4'd1;
         end else begin
            seq_error_d = 1'b1;
            acc_d       = '0;
            exp_row_d   = 4'd0;
            state_d     = IDLE;
         end
      end
   end

   always_comb begin
      shifted = fin_q >>> FRAC_BITS;
      if (shifted > SAT_MAX) begin
         sat_val = SAT_MAX[OUT_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_val = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
         sat_val = shifted[OUT_WIDTH-1:0];
      end
      res_d      = res_q;
      res_vld_d  = res_vld_q;
      overflow_d = overflow_q;
      if (fin_vld_q) begin
         if (!res_vld_q || result_ready) begin
            res_d     = sat_val;
            res_vld_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (result_ready) begin
         res_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         exp_row_q   <= '0;
         acc_q       <= '0;
         fin_q       <= '0;
         fin_vld_q   <= 1'b0;
         seq_error_q <= 1'b0;
         res_q       <= '0;
         res_vld_q   <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_row_q   <= exp_row_d;
         acc_q       <= acc_d;
         fin_q       <= fin_d;
         fin_vld_q   <= fin_vld_d;
         seq_error_q <= seq_error_d;
         res_q       <= res_d;
         res_vld_q   <= res_vld_d;
         overflow_q  <= overflow_d;
      end
   end

   assign result_out   = res_q;
   assign result_valid = res_vld_q;
   assign seq_error    = seq_error_q;
   assign overflow     = overflow_q;
endmodule

// File: doc/conv9_row_accumulator.md
CONV9_ROW_ACCUMULATOR -- requirements
Module: conv9_row_accumulator

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8: unsigned pixel width.
REQ-002 Parameter WEIGHT_WIDTH, default 18: signed weight width.
REQ-003 Parameter FRAC_BITS, default 10: arithmetic right shift applied to the final sum.
REQ-004 Parameter OUT_WIDTH, default 18: signed saturated result width.
REQ-005 Port clk_in, input, 1: the block's only clock; all logic on its rising edge.
REQ-006 Port rst_in, input, 1: reset, asynchronous and active-high.
REQ-007 Port weight_row_in, input, 9 x WEIGHT_WIDTH signed: one 9-tap kernel row, element 0 = leftmost tap.
REQ-008 Port row_num_in, input, 4: kernel row index 0..8 of weight_row_in.
REQ-009 Port pixel_row_in, input, 9 x PIXEL_WIDTH unsigned: 9-pixel window row aligned with weight_row_in.
REQ-010 Port data_valid_in, input, 1: weight_row_in, row_num_in and pixel_row_in valid this cycle.
REQ-011 Port result_out, output, OUT_WIDTH signed: saturated convolution result.
REQ-012 Port result_valid, output, 1: result_out holds an unconsumed result.
REQ-013 Port result_ready, input, 1: downstream accepts result_out when high with result_valid.
REQ-014 Port seq_error, output, 1: sticky, a row-order violation occurred.
REQ-015 Port overflow, output, 1: sticky, a completed result was dropped because the output register was occupied.

Function
REQ-016 Stage S1 SHALL register the 9 products: zero-extend each pixel to PIXEL_WIDTH+1 bits, then multiply it as a signed value by its weight.
REQ-017 Stage S2 SHALL register the signed sum of the 9 S1 products at full width, with no truncation.
REQ-018 Stage S3 SHALL hold a signed accumulator of width WEIGHT_WIDTH+PIXEL_WIDTH+1+8 bits.
REQ-019 row_num and valid SHALL travel with their data through S1 and S2.
REQ-020 Accumulator FSM states SHALL be IDLE and ACCUM, with an expected-row counter exp_row in 0..8.
REQ-021 IDLE, valid row 0 at S2: acc <= row sum, exp_row <= 1, go to ACCUM.
REQ-022 IDLE, valid nonzero row at S2: discard the row, set seq_error, stay in IDLE.
REQ-023 ACCUM, valid row == exp_row and < 8: acc += row sum, exp_row += 1.
REQ-024 ACCUM, valid row == 8 == exp_row: final = acc + row sum; load the output register; go to IDLE.
REQ-025 ACCUM, valid row 0: set seq_error, restart with acc <= row sum, exp_row <= 1.
REQ-026 ACCUM, any other row: set seq_error, discard the row and partial sum, go to IDLE.
REQ-027 Cycles with no valid row SHALL leave the FSM, acc and exp_row unchanged (gaps allowed).
REQ-028 Output value SHALL be final >>> FRAC_BITS, saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-029 Latency: row 8 presented on data_valid_in at cycle N SHALL give result_valid high at cycle N+4.
REQ-030 result_valid SHALL stay high, with result_out stable, until a cycle where result_ready is high; it drops the next cycle unless a new result loads.
REQ-031 New result with the register empty, or with the old result accepted the same cycle: load the new result, result_valid stays or goes high.
REQ-032 New result with the register occupied and not accepted: keep the old result, drop the new one, set overflow.
REQ-033 The input side SHALL have no backpressure; one row per cycle is sustained.

Reset
REQ-034 While rst_in is high, immediately: result_out=0, result_valid=0, seq_error=0, overflow=0, state IDLE, exp_row=0, acc=0, all pipeline valids 0.
REQ-035 Reset mid-frame SHALL discard all in-flight rows; the first valid row after release must be row 0 or seq_error sets.
REQ-036 seq_error and overflow SHALL clear only on reset.

Structure
REQ-037 Package conv9_pkg SHALL hold KERNEL_TAPS=9, KERNEL_ROWS=9, the FSM state enum, and the accumulator-width constant.
REQ-038 One sub-module, conv9_row_mac, SHALL implement S1 and S2: 9 multipliers plus a registered adder tree.

Verification
REQ-039 Rows 0..8 back to back, all weights 1<<FRAC_BITS, all pixels 1 -> one result, result_out=81, result_valid at N+4 after row 8.
REQ-040 Rows 0..4, row 6 -> seq_error=1, no result; then a clean frame 0..8 -> correct result.
REQ-041 All weights 2^17-1, all pixels 255 -> result_out=2^17-1 (saturated positive); all weights -2^17 -> -2^17.
REQ-042 result_ready held low across two complete frames -> first result kept, overflow=1; ready then high -> first value accepted.
REQ-043 Frame with 2 idle cycles between each row -> same result as the back-to-back frame.
REQ-044 rst_in asserted after row 5, then rows 0..8 -> no spurious result, correct final result, flags 0.
